clock_set_ctrl: RTL and testbench

Time-setting controller that sequences the digital clock counter block.
- Runs the counter in normal mode and freezes it while the user edits hours, minutes and seconds.
- The user edits with two debounced button pulses.
- The edited time is written back to the counter with a single-cycle load strobe.
- Sits between the button front end and the hrs/min/sec counter.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/mod_inc.sv | 15 +
 rtl/clock_set_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
// Defining CLK_SET_ALARM_EN adds the alarm-edit states to the state type.
package clock_pkg;

    localparam int HRS_W       = 4;
    localparam int MS_W        = 3;
    localparam int DEF_MAX_SEC = 6;
    localparam int DEF_MAX_HRS = 12;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HRS  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HRS,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
`ifdef CLK_SET_ALARM_EN
        ,
        ST_SET_AL_HRS,
        ST_SET_AL_MIN
`endif
    } state_t;

endpackage

// File: rtl/mod_inc.sv
// Modulo-N increment of a single time field; wraps MODULUS-1 back to 0.
module mod_inc #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // >= rather than == so a stray out-of-range value also lands back on 0
    always_comb nxt = (val >= LAST) ? '0 : val + WIDTH'(1);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the clock counter, edits a shadow copy, loads it back.
// Optional alarm editing/compare is compiled in with CLK_SET_ALARM_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int MAX_SEC = DEF_MAX_SEC,
    parameter int MAX_HRS = DEF_MAX_HRS,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
`ifdef CLK_SET_ALARM_EN
    input  logic             btn_alarm,
    output logic             alarm_out,
    output logic             alarm_on,
`endif
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MS_W-1:0]  cur_min,
    input  logic [MS_W-1:0]  cur_sec,
    output logic             run_en,
    output logic             load,
    output logic [HRS_W-1:0] load_hrs,
    output logic [MS_W-1:0]  load_min,
    output logic [MS_W-1:0]  load_sec,
    output logic [1:0]       sel
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, next_state;
    logic              run_en_d, load_d;
    logic [1:0]        sel_d;
    logic              in_set, timed_out;
    logic [CNT_W-1:0]  idle_cnt;
    logic              idle_tick;
    logic [HRS_W-1:0]  shd_hrs, hrs_nxt, cap_hrs;
    logic [MS_W-1:0]   shd_min, min_nxt, cap_min;
    logic [MS_W-1:0]   shd_sec, sec_nxt, cap_sec;
`ifdef CLK_SET_ALARM_EN
    logic [HRS_W-1:0]  al_hrs, al_hrs_nxt;
    logic [MS_W-1:0]   al_min, al_min_nxt;
`endif

    mod_inc #(.WIDTH(HRS_W), .MODULUS(MAX_HRS)) u_inc_hrs (.val(shd_hrs), .nxt(hrs_nxt));
    mod_inc #(.WIDTH(MS_W),  .MODULUS(MAX_SEC)) u_inc_min (.val(shd_min), .nxt(min_nxt));
    mod_inc #(.WIDTH(MS_W),  .MODULUS(MAX_SEC)) u_inc_sec (.val(shd_sec), .nxt(sec_nxt));
`ifdef CLK_SET_ALARM_EN
    mod_inc #(.WIDTH(HRS_W), .MODULUS(MAX_HRS)) u_inc_al_hrs (.val(al_hrs), .nxt(al_hrs_nxt));
    mod_inc #(.WIDTH(MS_W),  .MODULUS(MAX_SEC)) u_inc_al_min (.val(al_min), .nxt(al_min_nxt));
`endif

    assign load_hrs  = shd_hrs;
    assign load_min  = shd_min;
    assign load_sec  = shd_sec;
    assign timed_out = (idle_cnt == CNT_W'(TIMEOUT));

    // Live values that are out of range are captured as 0 so the shadows stay legal
    always_comb begin
        cap_hrs = (int'(cur_hrs) < MAX_HRS) ? cur_hrs : '0;
        cap_min = (int'(cur_min) < MAX_SEC) ? cur_min : '0;
        cap_sec = (int'(cur_sec) < MAX_SEC) ? cur_sec : '0;
    end

    always_comb begin
        in_set = (state == ST_SET_HRS) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
`ifdef CLK_SET_ALARM_EN
        if ((state == ST_SET_AL_HRS) || (state == ST_SET_AL_MIN))
            in_set = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            run_en <= 1'b1;
            load   <= 1'b0;
            sel    <= SEL_NONE;
        end else begin
            state  <= next_state;
            run_en <= run_en_d;
            load   <= load_d;
            sel    <= sel_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (btn_mode)
                    next_state = ST_SET_HRS;
`ifdef CLK_SET_ALARM_EN
                else if (btn_alarm && !alarm_on)
                    next_state = ST_SET_AL_HRS;
`endif
            end
            ST_SET_HRS: if (btn_mode) next_state = ST_SET_MIN;
            ST_SET_MIN: if (btn_mode) next_state = ST_SET_SEC;
            ST_SET_SEC: if (btn_mode) next_state = ST_COMMIT;
            ST_COMMIT:  next_state = ST_RUN;
`ifdef CLK_SET_ALARM_EN
            ST_SET_AL_HRS: if (btn_mode) next_state = ST_SET_AL_MIN;
            ST_SET_AL_MIN: if (btn_mode) next_state = ST_RUN;
`endif
            default:    next_state = ST_RUN;
        endcase
        if (in_set && !btn_mode && !btn_inc && timed_out)
            next_state = ST_RUN;
    end

    // Outputs are decoded from next_state so the registered copy tracks the state register
    always_comb begin
        run_en_d = 1'b0;
        load_d   = 1'b0;
        sel_d    = SEL_NONE;
        case (next_state)
            ST_RUN:     run_en_d = 1'b1;
            ST_SET_HRS: sel_d = SEL_HRS;
            ST_SET_MIN: sel_d = SEL_MIN;
            ST_SET_SEC: sel_d = SEL_SEC;
            ST_COMMIT:  load_d = 1'b1;
`ifdef CLK_SET_ALARM_EN
            ST_SET_AL_HRS: begin
                run_en_d = 1'b1;
                sel_d    = SEL_HRS;
            end
            ST_SET_AL_MIN: begin
                run_en_d = 1'b1;
                sel_d    = SEL_MIN;
            end
`endif
            default:    run_en_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_hrs   <= '0;
            shd_min   <= '0;
            shd_sec   <= '0;
            idle_cnt  <= '0;
            idle_tick <= 1'b0;
`ifdef CLK_SET_ALARM_EN
            al_hrs    <= '0;
            al_min    <= '0;
            alarm_on  <= 1'b0;
            alarm_out <= 1'b0;
`endif
        end else begin
            // Idle counter advances on every second quiet cycle and parks at TIMEOUT
            if (!in_set || btn_mode || btn_inc) begin
                idle_cnt  <= '0;
                idle_tick <= 1'b0;
            end else if (!timed_out) begin
                idle_tick <= ~idle_tick;
                if (idle_tick)
                    idle_cnt <= idle_cnt + CNT_W'(1);
            end

            case (state)
                ST_RUN: begin
                    if (btn_mode) begin
                        shd_hrs <= cap_hrs;
                        shd_min <= cap_min;
                        shd_sec <= cap_sec;
                    end
`ifdef CLK_SET_ALARM_EN
                    else if (btn_alarm && alarm_on)
                        alarm_on <= 1'b0;
`endif
                end
                ST_SET_HRS: if (btn_inc && !btn_mode) shd_hrs <= hrs_nxt;
                ST_SET_MIN: if (btn_inc && !btn_mode) shd_min <= min_nxt;
                ST_SET_SEC: if (btn_inc && !btn_mode) shd_sec <= sec_nxt;
`ifdef CLK_SET_ALARM_EN
                ST_SET_AL_HRS: if (btn_inc && !btn_mode) al_hrs <= al_hrs_nxt;
                ST_SET_AL_MIN: begin
                    if (btn_mode)
                        alarm_on <= 1'b1;
                    else if (btn_inc)
                        al_min <= al_min_nxt;
                end
`endif
                default: ;
            endcase

`ifdef CLK_SET_ALARM_EN
            alarm_out <= alarm_on && (cur_hrs == al_hrs) && (cur_min == al_min)
                         && (cur_sec == '0);
`endif
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized buttons
// against a behavioural model; alarm checks are included when CLK_SET_ALARM_EN is defined.
module tb_clock_set_ctrl;

    localparam int TO = 8;
    localparam int MS = 6;
    localparam int MH = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_hrs = '0;
    logic [2:0] cur_min = '0;
    logic [2:0] cur_sec = '0;
    logic       run_en, load;
    logic [3:0] load_hrs;
    logic [2:0] load_min, load_sec;
    logic [1:0] sel;
`ifdef CLK_SET_ALARM_EN
    logic       btn_alarm = 1'b0;
    logic       alarm_out, alarm_on;
    int         m_al[2] = '{0, 0};
    int         m_aon = 0;
    int         m_aout = 0;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int load_cnt = 0;
    bit chk_on = 1'b0;

    // Model: m_st 0=run 1=hrs 2=min 3=sec 4=commit 5=alarm hrs 6=alarm min
    int m_st = 0;
    int m_idle = 0;
    int m_sh[3] = '{0, 0, 0};

    clock_set_ctrl #(.MAX_SEC(MS), .MAX_HRS(MH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
`ifdef CLK_SET_ALARM_EN
        .btn_alarm(btn_alarm), .alarm_out(alarm_out), .alarm_on(alarm_on),
`endif
        .cur_hrs(cur_hrs), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .load(load), .load_hrs(load_hrs), .load_min(load_min),
        .load_sec(load_sec), .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fmod(input int st);
        return (st == 1 || st == 5) ? MH : MS;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0;
            m_idle = 0;
            m_sh = '{0, 0, 0};
`ifdef CLK_SET_ALARM_EN
            m_al = '{0, 0};
            m_aon = 0;
            m_aout = 0;
`endif
        end else begin
`ifdef CLK_SET_ALARM_EN
            m_aout = (m_aon != 0 && int'(cur_hrs) == m_al[0] && int'(cur_min) == m_al[1]
                      && cur_sec == 0) ? 1 : 0;
`endif
            case (m_st)
                0: begin
                    m_idle = 0;
                    if (btn_mode) begin
                        m_sh = '{int'(cur_hrs), int'(cur_min), int'(cur_sec)};
                        m_st = 1;
                    end
`ifdef CLK_SET_ALARM_EN
                    else if (btn_alarm) begin
                        if (m_aon != 0) m_aon = 0;
                        else m_st = 5;
                    end
`endif
                end
                1, 2, 3, 5, 6: begin
                    if (btn_mode) begin
                        m_idle = 0;
                        if (m_st == 6) begin
`ifdef CLK_SET_ALARM_EN
                            m_aon = 1;
`endif
                            m_st = 0;
                        end else begin
                            m_st = m_st + 1;
                        end
                    end else if (btn_inc) begin
                        m_idle = 0;
                        if (m_st <= 3) m_sh[m_st-1] = (m_sh[m_st-1] + 1) % fmod(m_st);
`ifdef CLK_SET_ALARM_EN
                        else m_al[m_st-5] = (m_al[m_st-5] + 1) % fmod(m_st);
`endif
                    end else if (m_idle == 2 * TO) begin
                        m_st = 0;
                    end else begin
                        m_idle++;
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (load === 1'b1) load_cnt++;
        if (chk_on && !rst) begin
            chk("run_en", int'(run_en), (m_st == 0 || m_st >= 5) ? 1 : 0);
            chk("load", int'(load), (m_st == 4) ? 1 : 0);
            chk("sel", int'(sel), (m_st >= 1 && m_st <= 3) ? m_st : (m_st >= 5 ? m_st - 4 : 0));
            chk("load_hrs", int'(load_hrs), m_sh[0]);
            chk("load_min", int'(load_min), m_sh[1]);
            chk("load_sec", int'(load_sec), m_sh[2]);
`ifdef CLK_SET_ALARM_EN
            chk("alarm_on", int'(alarm_on), m_aon);
            chk("alarm_out", int'(alarm_out), m_aout);
`endif
        end
    end

    task automatic press(input bit m, input bit i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hrs = 4'(h);
        cur_min = 3'(m);
        cur_sec = 3'(s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int waited;
        int lc0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_run_en", int'(run_en), 1);
        chk("rst_load", int'(load), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_load_all", int'({load_hrs, load_min, load_sec}), 0);

        // Full edit: 3:4:2 -> 5:5:2
        set_cur(3, 4, 2);
        press(1, 0);
        chk("edit_sel_hrs", int'(sel), 1);
        chk("edit_run_en", int'(run_en), 0);
        chk("capture_hrs", int'(load_hrs), 3);
        press(0, 1);
        press(0, 1);
        chk("inc_hrs", int'(load_hrs), 5);
        press(1, 0);
        chk("edit_sel_min", int'(sel), 2);
        press(0, 1);
        chk("inc_min", int'(load_min), 5);
        press(1, 0);
        chk("edit_sel_sec", int'(sel), 3);
        press(1, 0);
        chk("commit_load", int'(load), 1);
        chk("commit_vals", int'({load_hrs, load_min, load_sec}), {4'd5, 3'd5, 3'd2});
        chk("commit_run_en", int'(run_en), 0);
        @(negedge clk);
        chk("post_commit_load", int'(load), 0);
        chk("post_commit_run_en", int'(run_en), 1);

        // Wrap-around, no carry, mode beats inc
        set_cur(11, 5, 0);
        press(1, 0);
        chk("cap_hrs11", int'(load_hrs), 11);
        press(0, 1);
        chk("wrap_hrs", int'(load_hrs), 0);
        press(1, 0);
        press(0, 1);
        chk("wrap_min", int'(load_min), 0);
        chk("no_carry_hrs", int'(load_hrs), 0);
        press(1, 1);
        chk("mode_wins_sel", int'(sel), 3);
        chk("mode_wins_min", int'(load_min), 0);

        // Abandon by timeout from SET_SEC
        lc0 = load_cnt;
        waited = 0;
        while (!run_en && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("timeout_cycles", waited, 2 * TO + 1);
        chk("timeout_no_load", load_cnt, lc0);
        chk("timeout_run_en", int'(run_en), 1);
        chk("timeout_sel", int'(sel), 0);

        // Asynchronous reset in the middle of SET_SEC
        set_cur(9, 2, 3);
        press(1, 0);
        press(0, 1);
        press(1, 0);
        press(1, 0);
        chk("pre_rst_sel", int'(sel), 3);
        chk("pre_rst_hrs", int'(load_hrs), 10);
        lc0 = load_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_run_en", int'(run_en), 1);
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_load", int'(load), 0);
        chk("async_rst_hrs", int'(load_hrs), 0);
        chk("async_rst_sec", int'(load_sec), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_load", load_cnt, lc0);

`ifdef CLK_SET_ALARM_EN
        @(negedge clk);
        btn_alarm = 1'b1;
        @(negedge clk);
        btn_alarm = 1'b0;
        chk("al_run_en", int'(run_en), 1);
        press(0, 1);
        press(0, 1);
        press(1, 0);
        repeat (3) press(0, 1);
        press(1, 0);
        chk("al_on", int'(alarm_on), 1);
        set_cur(2, 3, 0);
        @(negedge clk);
        chk("al_out_hit", int'(alarm_out), 1);
        set_cur(2, 3, 1);
        @(negedge clk);
        chk("al_out_miss", int'(alarm_out), 0);
`endif

        // Randomized segments with varying button density
        for (int seg = 0; seg < 16; seg++) begin
            int rm;
            int ri;
            rm = $urandom_range(0, 30);
            ri = $urandom_range(0, 40);
            repeat (100) begin
                @(negedge clk);
                btn_mode = ($urandom_range(0, 99) < rm);
                btn_inc  = ($urandom_range(0, 99) < ri);
`ifdef CLK_SET_ALARM_EN
                btn_alarm = ($urandom_range(0, 99) < 5);
`endif
                set_cur($urandom_range(0, MH - 1), $urandom_range(0, MS - 1),
                        $urandom_range(0, MS - 1));
            end
        end
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
`ifdef CLK_SET_ALARM_EN
        btn_alarm = 1'b0;
`endif
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
